// File: rtl/pseudo_spi_scan_master_pkg.sv
// Shared definitions for the pseudo-SPI scan master: controller state
// encodings and default widths.
package pseudo_spi_scan_master_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 8;
  localparam int DIV_W_DEF  = 8;

  // Gray-ish walk through the transfer; each encoding is fixed because
  // the state is observed directly during bring-up.
  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_ADDR = 3'b001,
    S_READ = 3'b011,
    S_SOUT = 3'b010,
    S_LOOP = 3'b110,
    S_RDY  = 3'b100,
    S_DONE = 3'b101
  } spi_state_t;

endpackage

// File: rtl/pseudo_spi_scan_master_phase_gen.sv
// SOUT sub-phase generator: counts cycles spent in SOUT and flags when the
// scan master clock must be high in the following cycle and when SOUT ends.
module pseudo_spi_phase_gen
  import pseudo_spi_scan_master_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] freq_div,
  output logic             sclk1_nxt,
  output logic             sout_end
);

  // One extra bit so freq_div+2 never overflows.
  localparam int CNT_W = DIV_W + 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_ext;

  assign div_ext = {1'b0, freq_div};

  // Cycle index within the current SOUT; parked at zero outside SOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  // SCLK1 is registered, so it is requested one cycle early: cycles
  // 0..freq_div request it, giving high in cycles 1..freq_div+1.
  assign sclk1_nxt = en && (cnt <= div_ext);
  assign sout_end  = en && (cnt == div_ext + CNT_W'(2));

endmodule

// File: rtl/pseudo_spi_scan_master.sv
// Pseudo-SPI scan master: reads DATA_LEN+1 bytes from SRAM walking down
// from ADDR_BGN, shifts each LSB-first on SPI_SO with two-phase
// non-overlapping scan clocks, then pulses LAT to update the chain.
module pseudo_spi_scan_master
  import pseudo_spi_scan_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              BGN,
  input  logic [ADDR_W-1:0] ADDR_BGN,
  input  logic [LEN_W-1:0]  DATA_LEN,
  input  logic [DIV_W-1:0]  FREQ_DIV,
  input  logic [DATA_W-1:0] PI,
  output logic              SCLK1,
  output logic              SCLK2,
  output logic              LAT,
  output logic              SPI_SO,
  output logic              CEN,
  output logic [ADDR_W-1:0] A,
  output logic              D_WE,
  output logic              spi_is_done
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  spi_state_t spi_state, spi_state_nxt;

  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [LEN_W-1:0]  bytes_left, bytes_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;

  logic sout_en;
  logic sclk1_nxt;
  logic sout_end;

  assign sout_en = (spi_state == S_SOUT);
  assign D_WE    = 1'b0;

  pseudo_spi_phase_gen #(
    .DIV_W (DIV_W)
  ) u_phase_gen (
    .clk       (CLK),
    .rst       (RST),
    .en        (sout_en),
    .freq_div  (FREQ_DIV),
    .sclk1_nxt (sclk1_nxt),
    .sout_end  (sout_end)
  );

  // Next-state, counter and shift-register update logic.
  always_comb begin
    spi_state_nxt = spi_state;
    addr_nxt      = addr;
    bytes_nxt     = bytes_left;
    bit_nxt       = bit_cnt;
    shreg_nxt     = shreg;
    case (spi_state)
      S_IDLE: begin
        if (BGN) begin
          addr_nxt      = ADDR_BGN;
          bytes_nxt     = DATA_LEN;
          spi_state_nxt = S_ADDR;
        end
      end
      S_ADDR: spi_state_nxt = S_READ;
      S_READ: begin
        shreg_nxt     = PI;
        bit_nxt       = '0;
        spi_state_nxt = S_SOUT;
      end
      S_SOUT: begin
        if (sout_end) spi_state_nxt = S_LOOP;
      end
      S_LOOP: begin
        // Rotate rather than shift so every register bit stays live; the
        // wrapped bit is never sent because the byte ends first.
        shreg_nxt = {shreg[0], shreg[DATA_W-1:1]};
        bit_nxt   = bit_cnt + BIT_W'(1);
        if (bit_cnt != BIT_LAST) begin
          spi_state_nxt = S_SOUT;
        end else if (bytes_left != '0) begin
          bytes_nxt     = bytes_left - LEN_W'(1);
          addr_nxt      = addr - ADDR_W'(1);
          spi_state_nxt = S_ADDR;
        end else begin
          spi_state_nxt = S_RDY;
        end
      end
      S_RDY:  spi_state_nxt = S_DONE;
      S_DONE: begin
        if (!BGN) spi_state_nxt = S_IDLE;
      end
      default: spi_state_nxt = S_IDLE;
    endcase
  end

  // Control state and counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      spi_state  <= S_IDLE;
      addr       <= '0;
      bytes_left <= '0;
      bit_cnt    <= '0;
    end else begin
      spi_state  <= spi_state_nxt;
      addr       <= addr_nxt;
      bytes_left <= bytes_nxt;
      bit_cnt    <= bit_nxt;
    end
  end

  // Shift register holds data only, so it carries no reset.
  always_ff @(posedge CLK) begin
    shreg <= shreg_nxt;
  end

  // Outputs are registered from the upcoming state so each one is valid
  // for exactly the cycles its state occupies.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SCLK1       <= 1'b0;
      SCLK2       <= 1'b0;
      LAT         <= 1'b0;
      SPI_SO      <= 1'b0;
      CEN         <= 1'b1;
      A           <= '0;
      spi_is_done <= 1'b0;
    end else begin
      SCLK1       <= sclk1_nxt;
      SCLK2       <= (spi_state_nxt == S_LOOP);
      LAT         <= (spi_state_nxt == S_RDY);
      spi_is_done <= (spi_state_nxt == S_DONE);
      CEN         <= (spi_state_nxt != S_ADDR);
      if (spi_state_nxt == S_ADDR) A <= addr_nxt;
      // New bit appears in the setup cycle and is held through LOOP.
      if ((spi_state_nxt == S_SOUT) && (spi_state != S_SOUT)) SPI_SO <= shreg_nxt[0];
    end
  end

endmodule

// File: tb/tb_pseudo_spi_scan_master.sv
// Scoreboard bench for pseudo_spi_scan_master with an SRAM model and a
// 14-cell two-phase scan chain model.
module tb_pseudo_spi_scan_master;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BGN = 1'b0;
  logic [8:0] ADDR_BGN = '0;
  logic [7:0] DATA_LEN = '0;
  logic [7:0] FREQ_DIV = '0;
  logic [7:0] PI;
  logic       SCLK1, SCLK2, LAT, SPI_SO, CEN, D_WE, spi_is_done;
  logic [8:0] A;

  logic [7:0]  mem [0:511];
  logic [13:0] chain, po;

  logic       exp_bits [$];
  logic       last_bits [$];
  logic [8:0] exp_addr [$];

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 0;
  int loop_cnt, lat_cnt, cen_cnt, sclk1_cnt;

  always #5 CLK = ~CLK;

  pseudo_spi_scan_master dut (
    .CLK         (CLK),
    .RST         (RST),
    .BGN         (BGN),
    .ADDR_BGN    (ADDR_BGN),
    .DATA_LEN    (DATA_LEN),
    .FREQ_DIV    (FREQ_DIV),
    .PI          (PI),
    .SCLK1       (SCLK1),
    .SCLK2       (SCLK2),
    .LAT         (LAT),
    .SPI_SO      (SPI_SO),
    .CEN         (CEN),
    .A           (A),
    .D_WE        (D_WE),
    .spi_is_done (spi_is_done)
  );

  // Synchronous SRAM: Q valid one cycle after A/CEN.
  always @(posedge CLK) begin
    if (!CEN) PI <= mem[A];
  end

  // Scan chain: slave stage advances on SCLK2, update stage on LAT.
  always @(posedge SCLK2) chain <= {chain[12:0], SPI_SO};
  always @(posedge LAT)   po    <= chain;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Protocol monitor: pops the scoreboard as bits and addresses appear.
  always @(negedge CLK) begin
    if (mon_en) begin
      chk("nonoverlap", {31'b0, SCLK1 & SCLK2}, 32'd0);
      chk("d_we", {31'b0, D_WE}, 32'd0);
      if (SCLK1) begin
        sclk1_cnt++;
        if (exp_bits.size() > 0) chk("so_sout", {31'b0, SPI_SO}, {31'b0, exp_bits[0]});
      end
      if (SCLK2) begin
        loop_cnt++;
        if (exp_bits.size() > 0) chk("so_loop", {31'b0, SPI_SO}, {31'b0, exp_bits.pop_front()});
        else chk("bitq_size", exp_bits.size(), 32'd1);
      end
      if (LAT) lat_cnt++;
      if (!CEN) begin
        cen_cnt++;
        if (exp_addr.size() > 0) chk("sram_a", {23'b0, A}, {23'b0, exp_addr.pop_front()});
        else chk("addrq_size", exp_addr.size(), 32'd1);
      end
    end
  end

  task automatic run_xfer(input logic [8:0] ab, input logic [7:0] len,
                          input logic [7:0] div, input bit hold);
    int cyc, n_exp;
    logic [8:0] a;
    last_bits.delete();
    for (int i = 0; i <= int'(len); i++) begin
      a = ab - 9'(i);
      exp_addr.push_back(a);
      for (int k = 0; k < 8; k++) begin
        exp_bits.push_back(mem[a][k]);
        last_bits.push_back(mem[a][k]);
      end
    end
    loop_cnt = 0; lat_cnt = 0; cen_cnt = 0; sclk1_cnt = 0;
    n_exp = (int'(len) + 1) * (2 + 8 * (int'(div) + 4)) + 1;
    @(negedge CLK);
    ADDR_BGN = ab; DATA_LEN = len; FREQ_DIV = div; BGN = 1'b1; mon_en = 1;
    cyc = 0;
    while (!spi_is_done && cyc < n_exp + 50) begin
      @(negedge CLK);
      cyc++;
      if (!hold && cyc == 3) BGN = 1'b0;
    end
    chk("xfer_cycles", cyc, n_exp + 1);
    chk("loop_cycles", loop_cnt, 8 * (int'(len) + 1));
    chk("lat_pulses", lat_cnt, 1);
    chk("cen_cycles", cen_cnt, int'(len) + 1);
    chk("sclk1_cycles", sclk1_cnt, 8 * (int'(len) + 1) * (int'(div) + 1));
    chk("bits_left", exp_bits.size(), 0);
    chk("addrs_left", exp_addr.size(), 0);
    exp_bits.delete();
    exp_addr.delete();
    if (!hold) begin
      @(negedge CLK);
      chk("idle_after_done", {31'b0, spi_is_done}, 32'd0);
    end
    mon_en = 0;
  endtask

  initial begin
    logic [13:0] exp_po;
    int w;
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_cen", {31'b0, CEN}, 32'd1);
    chk("rst_sclk1", {31'b0, SCLK1}, 32'd0);
    chk("rst_sclk2", {31'b0, SCLK2}, 32'd0);
    chk("rst_lat", {31'b0, LAT}, 32'd0);
    chk("rst_so", {31'b0, SPI_SO}, 32'd0);
    chk("rst_a", {23'b0, A}, 32'd0);
    chk("rst_done", {31'b0, spi_is_done}, 32'd0);
    chk("rst_state", {29'b0, dut.spi_state}, 32'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Two bytes: 00 then AB, into the scan chain
    mem[1] = 8'h00; mem[0] = 8'hAB;
    run_xfer(9'd1, 8'd1, 8'd0, 1'b0);
    for (int k = 0; k < 14; k++) exp_po[k] = last_bits[15 - k];
    chk("chain_po", {18'b0, po}, {18'b0, exp_po});
    chk("cs208_po", {31'b0, po[0]}, {31'b0, mem[0][7]});

    // Single byte at address 0
    mem[0] = 8'h3C;
    run_xfer(9'd0, 8'd0, 8'd0, 1'b0);

    // Address walk wrapping below zero, random data, stretched SCLK1
    run_xfer(9'd1, 8'd3, 8'd1, 1'b0);

    // Divider
    run_xfer(9'h040, 8'd1, 8'd3, 1'b0);

    // Handshake: BGN held high after DONE
    run_xfer(9'h010, 8'd0, 8'd0, 1'b1);
    mon_en = 1; cen_cnt = 0;
    repeat (10) begin
      @(negedge CLK);
      chk("hold_done", {31'b0, spi_is_done}, 32'd1);
    end
    chk("hold_no_read", cen_cnt, 0);
    mon_en = 0;
    BGN = 1'b0;
    @(negedge CLK);
    chk("release_done", {31'b0, spi_is_done}, 32'd0);
    chk("release_state", {29'b0, dut.spi_state}, 32'd0);
    run_xfer(9'h020, 8'd0, 8'd2, 1'b0);

    // Reset in the middle of SOUT
    @(negedge CLK);
    ADDR_BGN = 9'h033; DATA_LEN = 8'd2; FREQ_DIV = 8'd2; BGN = 1'b1;
    w = 0;
    while (!SCLK1 && w < 100) begin
      @(negedge CLK);
      w++;
    end
    chk("reach_sout", {31'b0, SCLK1}, 32'd1);
    BGN = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("abort_cen", {31'b0, CEN}, 32'd1);
    chk("abort_sclk1", {31'b0, SCLK1}, 32'd0);
    chk("abort_sclk2", {31'b0, SCLK2}, 32'd0);
    chk("abort_lat", {31'b0, LAT}, 32'd0);
    chk("abort_done", {31'b0, spi_is_done}, 32'd0);
    chk("abort_state", {29'b0, dut.spi_state}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("abort_stays_idle", {31'b0, CEN}, 32'd1);

    // Recovery after abort
    run_xfer(9'd5, 8'd0, 8'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
